slot_executor: RTL and testbench

SLOT_EXECUTOR -- requirements
Module: slot_executor

---
 rtl/slot_pkg.sv | 20 ++
 rtl/slot_cycle_counter.sv | 27 ++
 rtl/slot_executor.sv | 165 ++++++++++++++++
 tb/tb_slot_executor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types for the slot executor: per-slot status codes and FSM state encoding.
package slot_pkg;

  typedef enum logic [1:0] {
    ST_PEND  = 2'd0,
    ST_DONE  = 2'd1,
    ST_ERROR = 2'd2,
    ST_SKIP  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4,
    S_FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/slot_cycle_counter.sv
// Saturating cycle counter; clear wins over enable, holds at all-ones.
module slot_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)                   count_d = '0;
    else if (en_i && ~&count_q)    count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/slot_executor.sv
// Walks slots 0..last_idx, issues one DMA command per slot, writes back status.
// Optional per-slot latency profiling is built when SLOT_EXEC_PROFILE_EN is defined.
module slot_executor
  import slot_pkg::*;
#(
  parameter int INPUT_IDX_WIDTH = 2,
  parameter int SRC_ADDR_WIDTH  = 32,
  parameter int SRC_SIZE_WIDTH  = 26,
  parameter int DST_ADDR_WIDTH  = 32,
  parameter int DST_SIZE_WIDTH  = 26,
  parameter int STATUS_WIDTH    = 2,
  parameter int PROFILE_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INPUT_IDX_WIDTH-1:0] last_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       run_error,
  output logic [INPUT_IDX_WIDTH-1:0] rd_idx,
  input  logic [SRC_ADDR_WIDTH-1:0]  rd_src_addr,
  input  logic [SRC_SIZE_WIDTH-1:0]  rd_src_size,
  input  logic [DST_ADDR_WIDTH-1:0]  rd_des_addr,
  input  logic [DST_SIZE_WIDTH-1:0]  rd_des_size,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [SRC_ADDR_WIDTH-1:0]  cmd_src_addr,
  output logic [SRC_SIZE_WIDTH-1:0]  cmd_src_size,
  output logic [DST_ADDR_WIDTH-1:0]  cmd_des_addr,
  output logic [DST_SIZE_WIDTH-1:0]  cmd_des_size,
  input  logic                       cmp_valid,
  input  logic                       cmp_error,
  output logic [INPUT_IDX_WIDTH-1:0] wb_idx,
  output logic [STATUS_WIDTH-1:0]    wb_status,
  output logic [PROFILE_WIDTH-1:0]   wb_profile,
  output logic                       wb_set_status,
  output logic                       wb_set_profile
);

  state_e                     state_q;
  status_e                    st_q, wb_status_q;
  logic [INPUT_IDX_WIDTH-1:0] rd_idx_q, last_q, wb_idx_q;
  logic [SRC_ADDR_WIDTH-1:0]  src_addr_q;
  logic [SRC_SIZE_WIDTH-1:0]  src_size_q;
  logic [DST_ADDR_WIDTH-1:0]  des_addr_q;
  logic [DST_SIZE_WIDTH-1:0]  des_size_q;
  logic                       cmd_valid_q, wb_set_status_q, done_q, run_error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      st_q            <= ST_PEND;
      wb_status_q     <= ST_PEND;
      rd_idx_q        <= '0;
      last_q          <= '0;
      wb_idx_q        <= '0;
      src_addr_q      <= '0;
      src_size_q      <= '0;
      des_addr_q      <= '0;
      des_size_q      <= '0;
      cmd_valid_q     <= 1'b0;
      wb_set_status_q <= 1'b0;
      done_q          <= 1'b0;
      run_error_q     <= 1'b0;
    end else begin
      wb_set_status_q <= 1'b0;
      done_q          <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_idx_q    <= '0;
            last_q      <= last_idx;
            run_error_q <= 1'b0;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          src_addr_q <= rd_src_addr;
          src_size_q <= rd_src_size;
          des_addr_q <= rd_des_addr;
          des_size_q <= rd_des_size;
          if (rd_src_size == '0) begin
            st_q            <= ST_SKIP;
            wb_status_q     <= ST_SKIP;
            wb_idx_q        <= rd_idx_q;
            wb_set_status_q <= 1'b1;
            state_q         <= S_WB;
          end else begin
            cmd_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completions are only honoured here, never in the handshake cycle.
          if (cmp_valid) begin
            st_q            <= cmp_error ? ST_ERROR : ST_DONE;
            wb_status_q     <= cmp_error ? ST_ERROR : ST_DONE;
            wb_idx_q        <= rd_idx_q;
            wb_set_status_q <= 1'b1;
            state_q         <= S_WB;
          end
        end
        S_WB: begin
          if (st_q == ST_ERROR || rd_idx_q == last_q) begin
            done_q      <= 1'b1;
            run_error_q <= (st_q == ST_ERROR);
            state_q     <= S_FINISH;
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
            state_q  <= S_FETCH;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign run_error     = run_error_q;
  assign rd_idx        = rd_idx_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_src_addr  = src_addr_q;
  assign cmd_src_size  = src_size_q;
  assign cmd_des_addr  = des_addr_q;
  assign cmd_des_size  = des_size_q;
  assign wb_idx        = wb_idx_q;
  assign wb_status     = STATUS_WIDTH'(wb_status_q);
  assign wb_set_status = wb_set_status_q;

`ifdef SLOT_EXEC_PROFILE_EN
  // Counter clears in FETCH (so skipped slots read 0) and runs every WAIT cycle,
  // so in WB it holds handshake-to-completion latency inclusive of the cmp cycle.
  logic                     wb_set_prof_q;
  logic [PROFILE_WIDTH-1:0] prof_cnt;

  slot_cycle_counter #(.WIDTH(PROFILE_WIDTH)) u_prof_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (state_q == S_FETCH),
    .en_i    (state_q == S_WAIT),
    .count_o (prof_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) wb_set_prof_q <= 1'b0;
    else       wb_set_prof_q <= (state_q == S_WAIT) && cmp_valid;
  end

  assign wb_profile     = prof_cnt;
  assign wb_set_profile = wb_set_prof_q;
`else
  assign wb_profile     = '0;
  assign wb_set_profile = 1'b0;
`endif

endmodule

// File: tb/tb_slot_executor.sv
// Directed bench for slot_executor (PROFILE_WIDTH=4); adapts profile expectations to SLOT_EXEC_PROFILE_EN.
module tb_slot_executor;

`ifdef SLOT_EXEC_PROFILE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, cmd_ready, cmp_valid, cmp_error;
  logic [1:0]  last_idx, rd_idx, wb_idx;
  logic        busy, done, run_error, cmd_valid, wb_set_status, wb_set_profile;
  logic [31:0] rd_src_addr, rd_des_addr, cmd_src_addr, cmd_des_addr;
  logic [25:0] rd_src_size, rd_des_size, cmd_src_size, cmd_des_size;
  logic [1:0]  wb_status;
  logic [3:0]  wb_profile;

  logic [31:0] m_src[4];
  logic [31:0] m_dst[4];
  logic [25:0] m_ssz[4];
  logic [25:0] m_dsz[4];
  logic        m_err[4];

  int total = 0, bad = 0;
  int n_hs = 0, n_wb = 0, n_sp = 0, n_done = 0;
  logic [31:0] hs_src[64];
  logic [1:0]  hs_idx[64];
  logic [1:0]  wl_idx[64], wl_st[64];
  logic [3:0]  wl_prof[64];
  logic        wl_sp[64];
  int cmp_lat, seen_hs = 0, cd = 0;
  logic spur, auto_v;
  logic [1:0] cur;

  always #5 clk = ~clk;

  assign rd_src_addr = m_src[rd_idx];
  assign rd_src_size = m_ssz[rd_idx];
  assign rd_des_addr = m_dst[rd_idx];
  assign rd_des_size = m_dsz[rd_idx];

  slot_executor #(.INPUT_IDX_WIDTH(2), .PROFILE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .last_idx(last_idx),
    .busy(busy), .done(done), .run_error(run_error), .rd_idx(rd_idx),
    .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
    .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_src_size(cmd_src_size),
    .cmd_des_addr(cmd_des_addr), .cmd_des_size(cmd_des_size),
    .cmp_valid(cmp_valid), .cmp_error(cmp_error),
    .wb_idx(wb_idx), .wb_status(wb_status), .wb_profile(wb_profile),
    .wb_set_status(wb_set_status), .wb_set_profile(wb_set_profile)
  );

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      if (n_hs < 64) begin hs_src[n_hs] = cmd_src_addr; hs_idx[n_hs] = rd_idx; end
      n_hs++;
    end
    if (wb_set_status) begin
      if (n_wb < 64) begin
        wl_idx[n_wb] = wb_idx; wl_st[n_wb] = wb_status;
        wl_prof[n_wb] = wb_profile; wl_sp[n_wb] = wb_set_profile;
      end
      n_wb++;
    end
    if (wb_set_profile) n_sp++;
    if (done) n_done++;
  end

  // Completion responder: cmp_valid lands cmp_lat cycles after each handshake.
  always @(posedge clk) begin
    #3;
    if (reset) begin
      cd = 0; seen_hs = n_hs;
    end else if (n_hs != seen_hs) begin
      seen_hs = n_hs; cd = cmp_lat; cur = hs_idx[(n_hs-1) % 64];
    end
    auto_v = 1'b0;
    if (cd > 0) begin cd--; if (cd == 0) auto_v = 1'b1; end
    cmp_valid = auto_v | spur;
    cmp_error = auto_v ? m_err[cur] : 1'b0;
  end

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(logic [1:0] li);
    start = 1'b1; last_idx = li;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(int bd, string nm);
    int k = 0;
    while (n_done == bd && k < 400) begin step(1); k++; end
    total++;
    if (n_done == bd) begin bad++; $display("FAIL %s_timeout: got no done want done", nm); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1;
    step(2);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
    total++; if (run_error !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", run_error); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmdv: got %0b want 0", cmd_valid); end
    total++; if (rd_idx !== 2'd0) begin bad++; $display("FAIL rst_rdidx: got %0d want 0", rd_idx); end
    total++; if ({wb_set_status, wb_set_profile} !== 2'b00) begin bad++; $display("FAIL rst_wbset: got %0b want 0", {wb_set_status, wb_set_profile}); end
    total++; if ({wb_status, wb_profile, wb_idx} !== 8'd0) begin bad++; $display("FAIL rst_wb: got %0h want 0", {wb_status, wb_profile, wb_idx}); end
    total++; if ({cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size} !== 116'd0) begin bad++; $display("FAIL rst_cmd: got %0h want 0", cmd_src_addr); end
    step(1);
    reset = 1'b0; start = 1'b0;
    step(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_prio: got busy %0b want 0", busy); end
  endtask

  task automatic test_basic;
    int bw = n_wb, bh = n_hs, bd = n_done;
    do_start(2'd2);
    wait_done(bd, "basic");
    total++; if (n_wb - bw !== 3) begin bad++; $display("FAIL basic_nwb: got %0d want 3", n_wb - bw); end
    for (int i = 0; i < 3; i++) begin
      total++; if (wl_idx[bw+i] !== 2'(i) || wl_st[bw+i] !== 2'd1) begin bad++; $display("FAIL basic_rec%0d: got idx %0d st %0d want idx %0d st 1", i, wl_idx[bw+i], wl_st[bw+i], i); end
      total++; if (wl_prof[bw+i] !== (PEN ? 4'd5 : 4'd0) || wl_sp[bw+i] !== PEN) begin bad++; $display("FAIL basic_prof%0d: got %0d/%0b want %0d/%0b", i, wl_prof[bw+i], wl_sp[bw+i], PEN ? 5 : 0, PEN); end
      total++; if (hs_src[bh+i] !== m_src[i]) begin bad++; $display("FAIL basic_cmd%0d: got %0h want %0h", i, hs_src[bh+i], m_src[i]); end
    end
    total++; if (n_hs - bh !== 3) begin bad++; $display("FAIL basic_nhs: got %0d want 3", n_hs - bh); end
    total++; if (n_done - bd !== 1 || run_error !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_end: got done %0d err %0b busy %0b want 1 0 0", n_done - bd, run_error, busy); end
  endtask

  task automatic test_skip;
    int bw = n_wb, bh = n_hs, bd = n_done;
    m_ssz[1] = 26'd0;
    do_start(2'd2);
    wait_done(bd, "skip");
    total++; if (n_wb - bw !== 3) begin bad++; $display("FAIL skip_nwb: got %0d want 3", n_wb - bw); end
    total++; if (wl_idx[bw+1] !== 2'd1 || wl_st[bw+1] !== 2'd3) begin bad++; $display("FAIL skip_rec: got idx %0d st %0d want 1 3", wl_idx[bw+1], wl_st[bw+1]); end
    total++; if (wl_sp[bw+1] !== 1'b0 || wl_prof[bw+1] !== 4'd0) begin bad++; $display("FAIL skip_prof: got %0b/%0d want 0/0", wl_sp[bw+1], wl_prof[bw+1]); end
    total++; if (wl_st[bw] !== 2'd1 || wl_st[bw+2] !== 2'd1 || wl_idx[bw+2] !== 2'd2) begin bad++; $display("FAIL skip_others: got %0d %0d idx %0d want 1 1 2", wl_st[bw], wl_st[bw+2], wl_idx[bw+2]); end
    total++; if (n_hs - bh !== 2) begin bad++; $display("FAIL skip_nhs: got %0d want 2", n_hs - bh); end
    m_ssz[1] = 26'h100;
  endtask

  task automatic test_error;
    int bw = n_wb, bh = n_hs, bd = n_done;
    m_err[0] = 1'b1;
    do_start(2'd3);
    wait_done(bd, "error");
    total++; if (n_wb - bw !== 1 || wl_idx[bw] !== 2'd0 || wl_st[bw] !== 2'd2) begin bad++; $display("FAIL err_rec: got n %0d idx %0d st %0d want 1 0 2", n_wb - bw, wl_idx[bw], wl_st[bw]); end
    total++; if (wl_prof[bw] !== (PEN ? 4'd5 : 4'd0) || wl_sp[bw] !== PEN) begin bad++; $display("FAIL err_prof: got %0d/%0b want %0d/%0b", wl_prof[bw], wl_sp[bw], PEN ? 5 : 0, PEN); end
    total++; if (n_hs - bh !== 1) begin bad++; $display("FAIL err_nhs: got %0d want 1", n_hs - bh); end
    total++; if (run_error !== 1'b1 || n_done - bd !== 1) begin bad++; $display("FAIL err_flag: got err %0b done %0d want 1 1", run_error, n_done - bd); end
    m_err[0] = 1'b0;
  endtask

  task automatic test_stall;
    int bw = n_wb, bh = n_hs, bd = n_done;
    spur = 1'b1; step(2); spur = 1'b0; step(1);
    total++; if (busy !== 1'b0 || n_wb !== bw || n_done !== bd) begin bad++; $display("FAIL idle_spur: got busy %0b wb %0d done %0d want 0 %0d %0d", busy, n_wb, n_done, bw, bd); end
    cmd_ready = 1'b0;
    do_start(2'd0);
    step(1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) spur = 1'b1;
      if (i == 6) spur = 1'b0;
      @(negedge clk);
      total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL stall_v%0d: got %0b want 1", i, cmd_valid); end
      total++; if (cmd_src_addr !== m_src[0] || cmd_des_addr !== m_dst[0]) begin bad++; $display("FAIL stall_addr%0d: got %0h/%0h want %0h/%0h", i, cmd_src_addr, cmd_des_addr, m_src[0], m_dst[0]); end
      total++; if (cmd_src_size !== m_ssz[0] || cmd_des_size !== m_dsz[0]) begin bad++; $display("FAIL stall_size%0d: got %0h/%0h want %0h/%0h", i, cmd_src_size, cmd_des_size, m_ssz[0], m_dsz[0]); end
      step(1);
    end
    total++; if (n_wb !== bw || n_hs !== bh) begin bad++; $display("FAIL stall_spur: got wb %0d hs %0d want %0d %0d", n_wb, n_hs, bw, bh); end
    cmd_ready = 1'b1;
    wait_done(bd, "stall");
    total++; if (n_wb - bw !== 1 || wl_st[bw] !== 2'd1 || wl_prof[bw] !== (PEN ? 4'd5 : 4'd0)) begin bad++; $display("FAIL stall_rec: got n %0d st %0d prof %0d want 1 1 %0d", n_wb - bw, wl_st[bw], wl_prof[bw], PEN ? 5 : 0); end
  endtask

  task automatic test_reset_wait;
    int bw, bd, k = 0, bh = n_hs;
    cmp_lat = 8;
    do_start(2'd1);
    while (n_hs == bh && k < 100) begin step(1); k++; end
    total++; if (n_hs == bh) begin bad++; $display("FAIL rw_hs_timeout: got no handshake want one"); end
    step(1);
    bw = n_wb; bd = n_done;
    reset = 1'b1;
    step(1);
    @(negedge clk);
    total++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || rd_idx !== 2'd0) begin bad++; $display("FAIL rw_state: got busy %0b cmdv %0b idx %0d want 0 0 0", busy, cmd_valid, rd_idx); end
    total++; if (wb_status !== 2'd0 || done !== 1'b0 || run_error !== 1'b0 || wb_set_status !== 1'b0) begin bad++; $display("FAIL rw_out: got st %0d done %0b err %0b set %0b want 0", wb_status, done, run_error, wb_set_status); end
    step(1);
    reset = 1'b0;
    step(10);
    total++; if (n_wb !== bw || n_done !== bd) begin bad++; $display("FAIL rw_nostrobe: got wb %0d done %0d want %0d %0d", n_wb, n_done, bw, bd); end
    cmp_lat = 5;
    do_start(2'd1);
    wait_done(bd, "rw_rerun");
    total++; if (n_wb - bw !== 2 || wl_idx[bw] !== 2'd0 || wl_idx[bw+1] !== 2'd1 || wl_st[bw+1] !== 2'd1) begin bad++; $display("FAIL rw_rerun: got n %0d idx %0d,%0d want 2 0,1", n_wb - bw, wl_idx[bw], wl_idx[bw+1]); end
  endtask

  task automatic test_saturate;
    int bw = n_wb, bd = n_done;
    cmp_lat = 20;
    do_start(2'd0);
    wait_done(bd, "sat");
    total++; if (wl_prof[bw] !== (PEN ? 4'd15 : 4'd0) || wl_sp[bw] !== PEN) begin bad++; $display("FAIL sat_prof: got %0d/%0b want %0d/%0b", wl_prof[bw], wl_sp[bw], PEN ? 15 : 0, PEN); end
  endtask

  task automatic test_full_run;
    int bw = n_wb, bd = n_done;
    cmp_lat = 3;
    do_start(2'd3);
    last_idx = 2'd0;
    step(4);
    start = 1'b1; step(1); start = 1'b0;
    wait_done(bd, "full");
    step(5);
    total++; if (n_wb - bw !== 4) begin bad++; $display("FAIL full_nwb: got %0d want 4", n_wb - bw); end
    for (int i = 0; i < 4; i++) begin
      total++; if (wl_idx[bw+i] !== 2'(i) || wl_st[bw+i] !== 2'd1 || wl_prof[bw+i] !== (PEN ? 4'd3 : 4'd0)) begin bad++; $display("FAIL full_rec%0d: got idx %0d st %0d prof %0d want %0d 1 %0d", i, wl_idx[bw+i], wl_st[bw+i], wl_prof[bw+i], i, PEN ? 3 : 0); end
    end
    total++; if (n_done - bd !== 1 || busy !== 1'b0 || rd_idx !== 2'd3) begin bad++; $display("FAIL full_end: got done %0d busy %0b idx %0d want 1 0 3", n_done - bd, busy, rd_idx); end
    total++; if (n_sp !== (PEN ? 14 : 0)) begin bad++; $display("FAIL sp_total: got %0d want %0d", n_sp, PEN ? 14 : 0); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd_ready = 1'b1; spur = 1'b0;
    cmp_valid = 1'b0; cmp_error = 1'b0; last_idx = 2'd0; cmp_lat = 5;
    for (int i = 0; i < 4; i++) begin
      m_src[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      m_dst[i] = 32'h8000_0000 + 32'(i) * 32'h40;
      m_ssz[i] = 26'h100;
      m_dsz[i] = 26'h100 + 26'(i);
      m_err[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_skip();
    test_error();
    test_stall();
    test_reset_wait();
    test_saturate();
    test_full_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
